pm_sensor_scan_sequencer: RTL and testbench
===========================================

// Module: pm_sensor_scan_sequencer
// PURPOSE
//  Autonomous scan engine for N process-monitor sensor wrappers. Walks enabled sensors
//  round-robin: request/ack handshake, reference-window measurement, serial counter readout.
//  Results go out on a valid/ready stream. Sits between the PM register interface and the
//  PMB logic wrappers, and replaces per-sensor software sequencing.
// PARAMETERS
//  N_SENS      4     number of sensor wrappers (1..63)
//  CNT_W       32    sensor counter width shifted out per sensor
//  REF_W       32    reference window counter width
//  ACK_TO      1023  handshake timeout in clk cycles (req->ack and ack release)
// PORTS
//  clk         in   1        single clock
//  rst_n       in   1        asynchronous active-low reset
//  start       in   1        pulse: begin scan (ignored while busy)
//  stop        in   1        pulse: abort scan
//  cont        in   1        1 = wrap and rescan forever; sampled on start
//  sens_mask   in   N_SENS   enabled sensors; sampled on start
//  ref_count   in   REF_W    measurement window in clk cycles; sampled on start
//  pmbw_req    out  N_SENS   request to wrapper (one-hot or zero)
//  pmbw_ack    in   N_SENS   acknowledge from wrapper
//  shift_en    out  N_SENS   serial shift enable (one-hot or zero)
//  select_ctr  out  N_SENS   select counter chain (one-hot or zero)
//  serial_out  in   N_SENS   serial data from wrappers
//  res_valid   out  1        result valid
//  res_ready   in   1        result accepted
//  res_idx     out  6        sensor index of result
//  res_data    out  CNT_W    captured counter value
//  busy        out  1        scan in progress
//  done        out  1        one-cycle pulse at end of non-continuous scan or abort
//  err_to      out  N_SENS   sticky timeout flag per sensor; cleared on start
//  alarm       out  N_SENS   sticky threshold flag (see CONFIGURATION)
// BEHAVIOUR
//  Reset: all outputs 0; FSM IDLE; rr pointer 0.
//  FSM: IDLE -> PICK -> REQ -> MEAS -> REL -> SHIFT -> OUT -> PICK.
//  PICK: next set bit in mask at or above ptr; 1 cycle. No further bit: wrap if cont,
//   else go to IDLE with done pulse.
//  REQ: pmbw_req[i]=1 until ack[i] is seen. Timeout after ACK_TO cycles: set err_to[i],
//   drop req, go to PICK (sensor skipped).
//  MEAS: req held; window counter loaded with max(ref_count,1), decrements each cycle;
//   leave at 1 -> 0 (exactly ref_count cycles, min 1).
//  REL: req dropped; wait ack[i]=0 with the same ACK_TO timeout (err_to, skip on expiry).
//  SHIFT: shift_en[i]=select_ctr[i]=1 for exactly CNT_W cycles; serial_out[i] sampled on
//   each edge, MSB first; shift register stays in the held state between sensors.
//  OUT: res_valid=1, idx/data stable until res_ready; transfer on valid&ready; ptr=i+1
//   (mod N_SENS).
//  mask==0 at start: busy is not raised; done pulses the next cycle.
//  stop in any state: req/shift_en/select_ctr drop the same cycle, pending res_valid
//   clears, FSM goes to IDLE, done pulses; start in the same cycle as stop is ignored.
//  start while busy: ignored. rst_n mid-scan: immediate return to reset values.
// CONFIGURATION
//  PM_SCAN_THRESH_EN defined: adds inputs thr_lo/thr_hi [CNT_W]. On every OUT transfer,
//   alarm[i] sets if res_data<thr_lo or res_data>thr_hi (unsigned). alarm clears on start.
//  Not defined: no threshold ports; alarm tied to 0.
// STRUCTURE
//  pm_scan_pkg: state enum, IDX_W=$clog2(N_SENS) function, ACK_TO default constant.
//  Sub-module pm_scan_rr_pick: combinational next-enabled-index finder
//   (mask, ptr -> idx, found, wrapped).
// TESTING
//  mask=4'b0101, ref_count=10, serial patterns A5A5A5A5/12345678 -> two results, idx 0 then 2;
//   done pulses; MEAS exactly 10 cycles.
//  ack[1] never rises, mask=4'b0010 -> err_to=4'b0010 after 1023 cycles, no result, done pulses.
//  res_ready held 0 for 50 cycles -> res_valid/idx/data stable; next sensor not requested.
//  cont=1, mask=4'b1001 -> idx sequence 0,3,0,3; stop asserted mid-SHIFT -> outputs low, done.
//  ref_count=0, mask=4'b0001 -> MEAS lasts 1 cycle; mask=0 -> done pulse, busy stays 0.
//  PM_SCAN_THRESH_EN, thr_lo=100, thr_hi=200, data=250 -> alarm[i]=1 until next start.

Source files
------------

// File: rtl/pm_scan_pkg.sv
// Shared types and constants for the PM sensor scan sequencer.
// State encoding, index-width helper, default handshake timeout.
package pm_scan_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PICK,
    S_REQ,
    S_MEAS,
    S_REL,
    S_SHIFT,
    S_OUT
  } state_e;

  localparam int ACK_TO_DEF = 1023;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pm_scan_rr_pick.sv
// Round-robin finder: lowest set mask bit at or above ptr.
// Ports: mask, ptr in; idx, found (mask nonzero), wrapped (hit below ptr) out.
module pm_scan_rr_pick
  import pm_scan_pkg::*;
#(
  parameter int N_SENS = 4,
  parameter int IDX_W  = 2
) (
  input  logic [N_SENS-1:0] mask,
  input  logic [IDX_W-1:0]  ptr,
  output logic [IDX_W-1:0]  idx,
  output logic              found,
  output logic              wrapped
);

  always_comb begin
    idx     = '0;
    found   = 1'b0;
    wrapped = 1'b0;
    // lowest set bit overall: the wrap-around candidate
    for (int k = N_SENS - 1; k >= 0; k--) begin
      if (mask[k]) begin
        idx     = IDX_W'(k);
        found   = 1'b1;
        wrapped = 1'b1;
      end
    end
    // a bit at or above ptr takes precedence
    for (int k = N_SENS - 1; k >= 0; k--) begin
      if (mask[k] && (k >= int'(ptr))) begin
        idx     = IDX_W'(k);
        wrapped = 1'b0;
      end
    end
  end

endmodule

// File: rtl/pm_sensor_scan_sequencer.sv
// Autonomous round-robin scan of PM sensor wrappers with stream output.
// Ports: start/stop/cont/sens_mask/ref_count control; pmbw_req/ack,
//   shift_en/select_ctr/serial_out to wrappers; res_valid/ready/idx/data
//   result stream; busy, done, err_to, alarm status.
// Optional: PM_SCAN_THRESH_EN adds thr_lo/thr_hi and drives alarm.
module pm_sensor_scan_sequencer
  import pm_scan_pkg::*;
#(
  parameter int N_SENS = 4,
  parameter int CNT_W  = 32,
  parameter int REF_W  = 32,
  parameter int ACK_TO = ACK_TO_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              cont,
  input  logic [N_SENS-1:0] sens_mask,
  input  logic [REF_W-1:0]  ref_count,
`ifdef PM_SCAN_THRESH_EN
  input  logic [CNT_W-1:0]  thr_lo,
  input  logic [CNT_W-1:0]  thr_hi,
`endif
  output logic [N_SENS-1:0] pmbw_req,
  input  logic [N_SENS-1:0] pmbw_ack,
  output logic [N_SENS-1:0] shift_en,
  output logic [N_SENS-1:0] select_ctr,
  input  logic [N_SENS-1:0] serial_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [5:0]        res_idx,
  output logic [CNT_W-1:0]  res_data,
  output logic              busy,
  output logic              done,
  output logic [N_SENS-1:0] err_to,
  output logic [N_SENS-1:0] alarm
);

  localparam int IDX_W = idx_w(N_SENS);
  localparam int TO_W  = $clog2(ACK_TO + 1);
  localparam int BIT_W = $clog2(CNT_W + 1);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    cur_q, cur_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic                wrap_q, wrap_d;
  logic [N_SENS-1:0]   mask_q, mask_d;
  logic [REF_W-1:0]    ref_q, ref_d;
  logic                cont_q, cont_d;
  logic [TO_W-1:0]     to_q, to_d;
  logic [REF_W-1:0]    win_q, win_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [CNT_W-1:0]    sreg_q, sreg_d;
  logic [N_SENS-1:0]   err_q, err_d;
  logic                done_q, done_d;

  logic [IDX_W-1:0]    pick_idx;
  logic                pick_found;
  logic                pick_wrap;
  logic [N_SENS-1:0]   cur_oh;
  logic                ack_cur;
  logic                ser_cur;
  logic                last;
  logic [IDX_W-1:0]    nxt_ptr;
  logic                to_hit;
  logic                start_acc;
  logic                xfer;

  pm_scan_rr_pick #(
    .N_SENS (N_SENS),
    .IDX_W  (IDX_W)
  ) u_pick (
    .mask    (mask_q),
    .ptr     (ptr_q),
    .idx     (pick_idx),
    .found   (pick_found),
    .wrapped (pick_wrap)
  );

  assign cur_oh    = N_SENS'(1) << cur_q;
  assign ack_cur   = pmbw_ack[cur_q];
  assign ser_cur   = serial_out[cur_q];
  assign last      = (cur_q == IDX_W'(N_SENS - 1));
  assign nxt_ptr   = last ? '0 : cur_q + IDX_W'(1);
  assign to_hit    = (to_q == TO_W'(ACK_TO - 1));
  assign start_acc = (state_q == S_IDLE) && start && !stop;
  assign xfer      = res_valid && res_ready;

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    ptr_d   = ptr_q;
    wrap_d  = wrap_q;
    mask_d  = mask_q;
    ref_d   = ref_q;
    cont_d  = cont_q;
    to_d    = to_q;
    win_d   = win_q;
    bit_d   = bit_q;
    sreg_d  = sreg_q;
    err_d   = err_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_acc) begin
          mask_d = sens_mask;
          ref_d  = ref_count;
          cont_d = cont;
          err_d  = '0;
          ptr_d  = '0;
          wrap_d = 1'b0;
          if (|sens_mask) state_d = S_PICK;
          else            done_d  = 1'b1;
        end
      end
      S_PICK: begin
        // wrap_q marks a pass that ran off the top index
        if (!pick_found ||
            ((wrap_q || pick_wrap) && !cont_q)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          cur_d   = pick_idx;
          wrap_d  = 1'b0;
          to_d    = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (ack_cur) begin
          win_d   = (ref_q == '0) ? REF_W'(1) : ref_q;
          state_d = S_MEAS;
        end else if (to_hit) begin
          err_d[cur_q] = 1'b1;
          ptr_d        = nxt_ptr;
          wrap_d       = last;
          state_d      = S_PICK;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      S_MEAS: begin
        if (win_q == REF_W'(1)) begin
          to_d    = '0;
          state_d = S_REL;
        end else begin
          win_d = win_q - REF_W'(1);
        end
      end
      S_REL: begin
        if (!ack_cur) begin
          bit_d   = '0;
          state_d = S_SHIFT;
        end else if (to_hit) begin
          err_d[cur_q] = 1'b1;
          ptr_d        = nxt_ptr;
          wrap_d       = last;
          state_d      = S_PICK;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      S_SHIFT: begin
        sreg_d = (sreg_q << 1) | CNT_W'(ser_cur);
        if (bit_q == BIT_W'(CNT_W - 1)) state_d = S_OUT;
        else                            bit_d   = bit_q + BIT_W'(1);
      end
      S_OUT: begin
        if (xfer) begin
          ptr_d   = nxt_ptr;
          wrap_d  = last;
          state_d = S_PICK;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (stop && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      done_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cur_q   <= '0;
      ptr_q   <= '0;
      wrap_q  <= 1'b0;
      mask_q  <= '0;
      ref_q   <= '0;
      cont_q  <= 1'b0;
      to_q    <= '0;
      win_q   <= '0;
      bit_q   <= '0;
      sreg_q  <= '0;
      err_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      ptr_q   <= ptr_d;
      wrap_q  <= wrap_d;
      mask_q  <= mask_d;
      ref_q   <= ref_d;
      cont_q  <= cont_d;
      to_q    <= to_d;
      win_q   <= win_d;
      bit_q   <= bit_d;
      sreg_q  <= sreg_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  // stop gates the wrapper strobes and result valid combinationally
  assign pmbw_req   = (((state_q == S_REQ) || (state_q == S_MEAS)) && !stop)
                      ? cur_oh : '0;
  assign shift_en   = ((state_q == S_SHIFT) && !stop) ? cur_oh : '0;
  assign select_ctr = shift_en;
  assign res_valid  = (state_q == S_OUT) && !stop;
  assign res_idx    = 6'(cur_q);
  assign res_data   = sreg_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign err_to     = err_q;

`ifdef PM_SCAN_THRESH_EN
  logic [N_SENS-1:0] alarm_q, alarm_d;

  always_comb begin
    alarm_d = alarm_q;
    if (start_acc) begin
      alarm_d = '0;
    end else if (xfer && ((sreg_q < thr_lo) || (sreg_q > thr_hi))) begin
      alarm_d[cur_q] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) alarm_q <= '0;
    else        alarm_q <= alarm_d;
  end

  assign alarm = alarm_q;
`else
  assign alarm = '0;
`endif

endmodule

// File: tb/tb_pm_sensor_scan_sequencer.sv
// Scoreboard bench for pm_sensor_scan_sequencer with wrapper models.
// Wrappers ack one cycle after req and shift their pattern MSB first.
module tb_pm_sensor_scan_sequencer;
  import pm_scan_pkg::*;

  localparam int N  = 4;
  localparam int CW = 32;
  localparam int RW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          cont = 1'b0;
  logic [N-1:0]  sens_mask = '0;
  logic [RW-1:0] ref_count = '0;
  logic [N-1:0]  pmbw_req;
  logic [N-1:0]  pmbw_ack = '0;
  logic [N-1:0]  shift_en;
  logic [N-1:0]  select_ctr;
  logic [N-1:0]  serial_out;
  logic          res_valid;
  logic          res_ready = 1'b1;
  logic [5:0]    res_idx;
  logic [CW-1:0] res_data;
  logic          busy;
  logic          done;
  logic [N-1:0]  err_to;
  logic [N-1:0]  alarm;
`ifdef PM_SCAN_THRESH_EN
  logic [CW-1:0] thr_lo = '0;
  logic [CW-1:0] thr_hi = '1;
`endif

  always #5 clk = ~clk;

  pm_sensor_scan_sequencer #(
    .N_SENS (N),
    .CNT_W  (CW),
    .REF_W  (RW),
    .ACK_TO (1023)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .cont       (cont),
    .sens_mask  (sens_mask),
    .ref_count  (ref_count),
`ifdef PM_SCAN_THRESH_EN
    .thr_lo     (thr_lo),
    .thr_hi     (thr_hi),
`endif
    .pmbw_req   (pmbw_req),
    .pmbw_ack   (pmbw_ack),
    .shift_en   (shift_en),
    .select_ctr (select_ctr),
    .serial_out (serial_out),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_idx    (res_idx),
    .res_data   (res_data),
    .busy       (busy),
    .done       (done),
    .err_to     (err_to),
    .alarm      (alarm)
  );

  int n_run = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // wrapper models
  logic [CW-1:0] pat [N];
  logic [N-1:0]  ack_en = '1;
  int            scnt [N];

  always @(posedge clk) begin
    pmbw_ack <= pmbw_req & ack_en;
    for (int i = 0; i < N; i++)
      scnt[i] <= shift_en[i] ? scnt[i] + 1 : 0;
  end

  always_comb begin
    serial_out = '0;
    for (int i = 0; i < N; i++)
      if (scnt[i] < CW) serial_out[i] = pat[i][CW-1-scnt[i]];
  end

  // scoreboard and monitors
  logic [5:0]    exp_idx [$];
  logic [CW-1:0] exp_dat [$];
  int n_res = 0;
  int hi_cnt = 0;
  int req1_cnt = 0;

  always begin
    @(negedge clk);
    #1;
    if (rst_n) begin
      if ((pmbw_req & pmbw_ack) != '0) hi_cnt <= hi_cnt + 1;
      if (pmbw_req[1]) req1_cnt <= req1_cnt + 1;
      if (res_valid && res_ready) begin
        n_res <= n_res + 1;
        if (exp_idx.size() == 0) begin
          chk("sb_extra_result", 64'(res_valid), 64'd0);
        end else begin
          chk("res_idx", 64'(res_idx), 64'(exp_idx.pop_front()));
          chk("res_data", 64'(res_data), 64'(exp_dat.pop_front()));
        end
      end
    end
  end

  task automatic push(input int i);
    exp_idx.push_back(6'(i));
    exp_dat.push_back(pat[i]);
  endtask

  task automatic go(input logic [N-1:0] m, input logic [RW-1:0] r,
                    input logic c);
    @(negedge clk);
    sens_mask = m;
    ref_count = r;
    cont      = c;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int max, input string tag);
    int seen = 0;
    for (int i = 0; i < max && seen == 0; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk(tag, 64'(seen), 64'd1);
  endtask

  int b_hi, b_res, b_req1, bad, reqs, got;
  logic [5:0]    cap_idx;
  logic [CW-1:0] cap_dat;

  initial begin
    pat[0] = 32'hA5A5A5A5;
    pat[1] = 32'hDEADBEEF;
    pat[2] = 32'h12345678;
    pat[3] = 32'h0F0F1234;

    // reset state
    #12;
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_req", 64'(pmbw_req), 0);
    chk("rst_shift", 64'(shift_en), 0);
    chk("rst_valid", 64'(res_valid), 0);
    chk("rst_err", 64'(err_to), 0);
    chk("rst_alarm", 64'(alarm), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // two-sensor scan, MEAS 10 cycles each (+1 req&ack cycle in REQ)
    push(0);
    push(2);
    b_hi  = hi_cnt;
    b_res = n_res;
    go(4'b0101, 10, 1'b0);
    chk("basic_busy", 64'(busy), 1);
    wait_done(1000, "basic_done");
    chk("basic_idle", 64'(busy), 0);
    @(negedge clk);
    chk("basic_nres", 64'(n_res - b_res), 2);
    chk("basic_meas", 64'(hi_cnt - b_hi), 22);
    chk("basic_sb_empty", 64'(exp_idx.size()), 0);

    // timeout on sensor 1
    ack_en = 4'b1101;
    b_res  = n_res;
    b_req1 = req1_cnt;
    go(4'b0010, 10, 1'b0);
    wait_done(1500, "to_done");
    @(negedge clk);
    chk("to_err", 64'(err_to), 64'h2);
    chk("to_req_cycles", 64'(req1_cnt - b_req1), 1023);
    chk("to_nres", 64'(n_res - b_res), 0);
    ack_en = '1;

    // back-pressure stall; start while busy is ignored
    push(0);
    push(1);
    res_ready = 1'b0;
    go(4'b0011, 5, 1'b0);
    chk("err_clr", 64'(err_to), 0);
    got = 0;
    for (int i = 0; i < 500 && got == 0; i++) begin
      @(negedge clk);
      if (res_valid) got = 1;
    end
    chk("stall_valid", 64'(got), 1);
    cap_idx = res_idx;
    cap_dat = res_data;
    bad  = 0;
    reqs = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (i == 10) begin
        sens_mask = 4'hF;
        start     = 1'b1;
      end
      if (i == 11) start = 1'b0;
      if (!res_valid || res_idx != cap_idx || res_data != cap_dat) bad++;
      if (pmbw_req != '0 || shift_en != '0) reqs++;
    end
    chk("stall_stable", 64'(bad), 0);
    chk("stall_no_req", 64'(reqs), 0);
    res_ready = 1'b1;
    wait_done(1000, "stall_done");
    chk("stall_sb_empty", 64'(exp_idx.size()), 0);

    // continuous 0,3,0,3 then stop mid-SHIFT
    push(0);
    push(3);
    push(0);
    push(3);
    b_res = n_res;
    go(4'b1001, 4, 1'b1);
    got = 0;
    for (int i = 0; i < 3000 && got == 0; i++) begin
      @(negedge clk);
      if (n_res - b_res >= 4) got = 1;
    end
    chk("cont_four", 64'(got), 1);
    got = 0;
    for (int i = 0; i < 500 && got == 0; i++) begin
      @(negedge clk);
      if (shift_en != '0) got = 1;
    end
    chk("cont_shift", 64'(got), 1);
    repeat (5) @(negedge clk);
    stop = 1'b1;
    #1;
    chk("stop_shift", 64'(shift_en), 0);
    chk("stop_sel", 64'(select_ctr), 0);
    @(negedge clk);
    stop = 1'b0;
    chk("stop_done", 64'(done), 1);
    chk("stop_busy", 64'(busy), 0);
    chk("stop_valid", 64'(res_valid), 0);
    repeat (60) @(negedge clk);
    chk("cont_sb_empty", 64'(exp_idx.size()), 0);

    // ref_count 0 -> one MEAS cycle
    push(0);
    b_hi = hi_cnt;
    go(4'b0001, 0, 1'b0);
    wait_done(500, "ref0_done");
    @(negedge clk);
    chk("ref0_meas", 64'(hi_cnt - b_hi), 2);
    chk("ref0_sb_empty", 64'(exp_idx.size()), 0);

    // empty mask
    go(4'b0000, 5, 1'b0);
    chk("m0_done", 64'(done), 1);
    chk("m0_busy", 64'(busy), 0);
    @(negedge clk);
    chk("m0_done_pulse", 64'(done), 0);

    // reset mid-scan
    go(4'b0001, 100, 1'b0);
    repeat (20) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstm_busy", 64'(busy), 0);
    chk("rstm_req", 64'(pmbw_req), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

`ifdef PM_SCAN_THRESH_EN
    thr_lo = 100;
    thr_hi = 200;
    pat[0] = 250;
    push(0);
    go(4'b0001, 3, 1'b0);
    wait_done(500, "thr_done");
    chk("thr_alarm", 64'(alarm), 64'h1);
    go(4'b0000, 3, 1'b0);
    chk("thr_clear", 64'(alarm), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
